hd_unload_serializer: RTL

Downstream consumer of the bit-node (LLR) memory's hard-decision unload port. On `start` it walks the memory's unload addresses, captures each registered 448-bit hard-decision vector (14 systematic circulants × 32 bits), and streams it out as 32-bit words over a valid/ready interface, masking the pad bit of each circulant's final word. It sits between the LDPC decoder core and the decoded-data output path. The only upstream it drives is the memory's `unload_en`/`unloadAddress` pair.

---
 rtl/hd_unload_serializer_if.sv | 30 +++
 rtl/hd_unload_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hd_unload_serializer_if.sv
// hd_unload_serializer_if
//   Valid/ready word stream produced by the hard-decision unload serializer.
//   Ports:
//     out_data  - output word (HDWIDTH bits)
//     out_valid - out_data is valid
//     out_ready - downstream accepts the word
//     out_last  - final word of the decoded block
//   Modports: master (serializer side), slave (consumer side).
interface hd_unload_serializer_if #(
  parameter int HDWIDTH = 32
);
  logic [HDWIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/hd_unload_serializer.sv
// hd_unload_serializer
//   Walks the bit-node memory's unload addresses, captures each registered
//   Kb*HDWIDTH hard-decision vector and streams it out one circulant word at
//   a time (address-major, column-minor), zeroing the pad bits beyond Z in
//   the final address.
//   Ports:
//     clk                     - clock, rising edge
//     rst                     - asynchronous active-low reset
//     start                   - one-cycle block request, honoured only in IDLE
//     busy                    - block in progress (ISSUE..SHIFT)
//     done                    - one-cycle pulse after the final word is accepted
//     unload_en               - memory unload read strobe
//     unloadAddress           - memory unload address, held between reads
//     unload_HDout_vec_regout - registered hard-decision vector from memory
//     out_if                  - valid/ready output word stream (master)
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for start; address/column counters held at zero
//   S_ISSUE   | unload_en pulse for the current address
//   S_WAIT    | covers the remaining memory read latency (RD_LAT-1 cycles)
//   S_CAPTURE | loads the capture register, resets the column counter
//   S_SHIFT   | presents one column word per accepted handshake
//   S_DONE    | done pulse, returns to idle
module hd_unload_serializer #(
  parameter int Z            = 511,
  parameter int Kb           = 14,
  parameter int HDWIDTH      = 32,
  parameter int ADDRESSWIDTH = 5,
  parameter int UNLOAD_DEPTH = 16,
  parameter int RD_LAT       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  input  logic [Kb*HDWIDTH-1:0]   unload_HDout_vec_regout,
  hd_unload_serializer_if.master  out_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam int WW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  // WAIT lasts RD_LAT-1 cycles; the down-counter exits on zero.
  localparam logic [WW-1:0]           WAIT_LOAD = WW'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
  localparam logic [3:0]              LAST_COL  = 4'(Kb - 1);
  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(UNLOAD_DEPTH - 1);

  // Bits of the last address that fall beyond the circulant size are pad.
  function automatic logic [HDWIDTH-1:0] last_addr_mask();
    logic [HDWIDTH-1:0] m;
    for (int j = 0; j < HDWIDTH; j++) begin
      m[j] = (((UNLOAD_DEPTH - 1) * HDWIDTH + j) < Z);
    end
    return m;
  endfunction

  localparam logic [HDWIDTH-1:0] LAST_MASK = last_addr_mask();

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [ADDRESSWIDTH-1:0] unload_addr_q;
  logic [3:0]              col_q, col_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [Kb*HDWIDTH-1:0]   cap_q;
  logic                    cap_load;
  logic                    shift_valid;
  logic [HDWIDTH-1:0]      cap_word [Kb];
  logic [HDWIDTH-1:0]      word_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      col_q         <= '0;
      wait_q        <= '0;
      cap_q         <= '0;
      unload_addr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      wait_q  <= wait_d;
      if (cap_load) begin
        cap_q <= unload_HDout_vec_regout;
      end
      // Address output only moves when a new read is issued.
      if (state_d == S_ISSUE) begin
        unload_addr_q <= addr_d;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    col_d       = col_q;
    wait_d      = wait_q;
    cap_load    = 1'b0;
    unload_en   = 1'b0;
    shift_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        col_d  = '0;
        if (start) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        unload_en = 1'b1;
        wait_d    = WAIT_LOAD;
        state_d   = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        cap_load = 1'b1;
        col_d    = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        shift_valid = 1'b1;
        if (out_if.out_ready) begin
          if (col_q == LAST_COL) begin
            if (addr_q == LAST_ADDR) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_ISSUE;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        addr_d  = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    for (int c = 0; c < Kb; c++) begin
      cap_word[c] = cap_q[c*HDWIDTH +: HDWIDTH];
    end
  end

  always_comb begin
    word_sel = '0;
    if (int'(col_q) < Kb) begin
      word_sel = cap_word[col_q];
    end
    if (addr_q == LAST_ADDR) begin
      word_sel = word_sel & LAST_MASK;
    end
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign unloadAddress = unload_addr_q;

  assign out_if.out_valid = shift_valid;
  assign out_if.out_data  = shift_valid ? word_sel : '0;
  assign out_if.out_last  = shift_valid && (addr_q == LAST_ADDR) && (col_q == LAST_COL);

endmodule
